// File: rtl/instr_aligner_if.sv
// Fetch-side and instruction-side handshake bundle for instr_aligner.
// slave = the aligner, master = fetch unit / decoder side.
interface instr_aligner_if;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        compressed_o;
  logic        illegal_o;

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, flush_i, flush_pc_i, instr_ready_i,
    output fetch_ready_o, instr_valid_o, instr_o, instr_pc_o, compressed_o, illegal_o
  );

  modport master (
    output fetch_valid_i, fetch_rdata_i, flush_i, flush_pc_i, instr_ready_i,
    input  fetch_ready_o, instr_valid_o, instr_o, instr_pc_o, compressed_o, illegal_o
  );
endinterface

// File: rtl/instr_aligner.sv
// Word FIFO + halfword aligner; a word pushed in cycle N is presentable in N+1, fetch_ready is count<DEPTH only.
// Define RVC_EN for 16/32-bit mixed streams; without it every instruction is a whole 32-bit word.
module instr_aligner #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst_n,
  instr_aligner_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_q;
  logic          off_q;

  logic [31:0] head_word;
  logic        push;
  logic        pop;
  logic        pop_on_hs;
  logic        hs;
  logic        dec_vld;
  logic        dec_comp;
  logic        dec_ill;
  logic [31:0] dec_instr;
  logic [31:0] pc_step;
  logic        off_nxt;
  logic [31:0] flush_pc_eff;
  logic        unused_flush_bits;

  assign head_word         = mem_q[head_q];
  assign unused_flush_bits = ^bus.flush_pc_i[1:0];

`ifdef RVC_EN
  logic [AW-1:0] head_inc;
  logic [31:0]   next_word;
  logic [15:0]   parcel;

  assign head_inc  = head_q + AW'(1);
  assign next_word = mem_q[head_inc];

  always_comb begin
    parcel    = off_q ? head_word[31:16] : head_word[15:0];
    dec_comp  = (parcel[1:0] != 2'b11);
    dec_ill   = (parcel == 16'h0000);
    dec_vld   = 1'b0;
    dec_instr = '0;
    if (dec_comp) begin
      dec_instr = {16'h0000, parcel};
      dec_vld   = (count_q != '0);
    end else if (!off_q) begin
      dec_instr = head_word;
      dec_vld   = (count_q != '0);
    end else begin
      // Spanning instruction needs the low half of the following word.
      dec_instr = {next_word[15:0], head_word[31:16]};
      dec_vld   = (count_q >= CW'(2));
    end
  end

  assign pc_step      = dec_comp ? 32'd2 : 32'd4;
  assign pop_on_hs    = off_q || !dec_comp;
  assign off_nxt      = off_q ^ dec_comp;
  assign flush_pc_eff = {bus.flush_pc_i[31:1], 1'b0};
`else
  always_comb begin
    dec_comp  = 1'b0;
    dec_instr = head_word;
    dec_vld   = (count_q != '0);
    dec_ill   = (head_word[1:0] != 2'b11);
  end

  assign pc_step      = 32'd4;
  assign pop_on_hs    = 1'b1;
  assign off_nxt      = 1'b0;
  assign flush_pc_eff = {bus.flush_pc_i[31:2], 2'b00};
`endif

  assign bus.fetch_ready_o = (count_q < FULL_CNT);
  assign bus.instr_valid_o = dec_vld && !bus.flush_i;
  assign bus.instr_o       = bus.instr_valid_o ? dec_instr : '0;
  assign bus.compressed_o  = bus.instr_valid_o && dec_comp;
  assign bus.illegal_o     = bus.instr_valid_o && dec_ill;
  assign bus.instr_pc_o    = pc_q;

  assign push = bus.fetch_valid_i && bus.fetch_ready_o;
  assign hs   = bus.instr_valid_o && bus.instr_ready_i;
  assign pop  = hs && pop_on_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= BOOT_ADDR;
      off_q   <= 1'b0;
    end else if (bus.flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= flush_pc_eff;
      off_q   <= flush_pc_eff[1];
    end else begin
      if (push) begin
        mem_q[tail_q] <= bus.fetch_rdata_i;
        tail_q        <= tail_q + AW'(1);
      end
      if (pop) head_q <= head_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (hs) begin
        pc_q  <= pc_q + pc_step;
        off_q <= off_nxt;
      end
    end
  end

endmodule
